gap_scan_scheduler: RTL and testbench

Shares one gap-finder engine (16-bit data word in, 4-bit longest-zero-gap result out) among `N_REQ` requesters. A round-robin arbiter picks a pending request and loads its word into the engine. The scheduler then pulses the engine start, waits for done or a timeout, and returns the result tagged with the requester id. It sits between client blocks and the single engine instance.

---
 rtl/gap_scan_scheduler.sv | 148 ++++++++++++++
 tb/tb_gap_scan_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gap_scan_scheduler.sv
// rtl/gap_scan_scheduler.sv - round-robin scheduler sharing one gap-finder engine among N_REQ requesters
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req, req_data  : per-requester request level and data word (word i at [i*DATA_W +: DATA_W])
//   gnt            : one-hot, one-cycle accept pulse
//   eng_start      : one-cycle engine start
//   eng_data       : word driven to the engine, stable from ISSUE through RESP
//   eng_done       : engine result valid (pulse or level), observed only in WAIT
//   eng_gap        : engine result
//   resp_valid     : one-cycle response pulse
//   resp_id        : requester served (holds between responses)
//   resp_gap       : engine result, 0 on timeout (holds between responses)
//   resp_timeout   : response was a timeout abort (holds between responses)
module gap_scan_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int GAP_W   = 4,
  parameter int TIMEOUT = 31,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_data,
  input  logic                    eng_done,
  input  logic [GAP_W-1:0]        eng_gap,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [GAP_W-1:0]        resp_gap,
  output logic                    resp_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   pick_id;
  logic              pick_found;
  logic [DATA_W-1:0] data_reg;
  logic [7:0]        tcnt;
  logic              tmo_hit;

  assign tmo_hit  = (tcnt == 8'(TIMEOUT));
  assign eng_data = data_reg;

  // Round-robin pick: first set request bit at or above ptr, wrapping around.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req[(int'(ptr) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    eng_start  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        gnt[cur_id] = 1'b1;
        eng_start   = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // done takes precedence over a timeout in the same cycle
        if (eng_done || tmo_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      cur_id       <= '0;
      data_reg     <= '0;
      tcnt         <= '0;
      resp_id      <= '0;
      resp_gap     <= '0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            cur_id   <= pick_id;
            data_reg <= req_data[int'(pick_id)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          ptr  <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
          tcnt <= '0;
        end
        WAIT: begin
          // resp_id is loaded here so it already shows cur_id during RESP and then holds
          if (eng_done) begin
            resp_gap     <= eng_gap;
            resp_timeout <= 1'b0;
            resp_id      <= cur_id;
          end else if (tmo_hit) begin
            resp_gap     <= '0;
            resp_timeout <= 1'b1;
            resp_id      <= cur_id;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gap_scan_scheduler.sv
// tb/tb_gap_scan_scheduler.sv - scoreboard bench for gap_scan_scheduler with engine and requester models
module tb_gap_scan_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int GW = 4;
  localparam int TO = 31;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            eng_start;
  logic [DW-1:0]   eng_data;
  logic            eng_done = 1'b0;
  logic [GW-1:0]   eng_gap = '0;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [GW-1:0]   resp_gap;
  logic            resp_timeout;

  gap_scan_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .eng_start    (eng_start),
    .eng_data     (eng_data),
    .eng_done     (eng_done),
    .eng_gap      (eng_gap),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_gap     (resp_gap),
    .resp_timeout (resp_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Longest run of zeros bounded by ones on both sides.
  function automatic int bgap(input logic [DW-1:0] w);
    int best;
    int last;
    best = 0;
    last = -1;
    for (int b = 0; b < DW; b++) begin
      if (w[b]) begin
        if (last >= 0 && (b - last - 1) > best) best = b - last - 1;
        last = b;
      end
    end
    return best;
  endfunction

  typedef struct {
    int id;
    int gap;
    int to;
    int lat;
    int gcyc;
  } exp_t;

  exp_t         sb_q[$];
  int           mptr = 0;
  int           eng_delay = 0;   // >=0 done delay, -1 never, -2 pulse in ISSUE only
  bit           rand_delay = 1'b0;
  int           cyc = 0;
  int           wc[N];
  logic [N-1:0] req_prev = '0;
  logic [N*DW-1:0] data_prev = '0;

  // Engine model
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start) begin
        if (eng_delay == -2) begin
          eng_done = 1'b1;
          eng_gap  = GW'($urandom_range(1, 15));
          @(posedge clk);
          #1 eng_done = 1'b0;
        end else if (eng_delay >= 0) begin
          @(posedge clk);
          repeat (eng_delay) @(posedge clk);
          #1;
          eng_done = 1'b1;
          eng_gap  = GW'(bgap(eng_data));
          @(posedge clk);
          #1 eng_done = 1'b0;
        end
      end
    end
  end

  // Monitor: predicts each grant from last-cycle requests, checks responses
  initial begin
    exp_t          e;
    int            id;
    int            mx;
    logic [DW-1:0] w;
    int            r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (gnt != '0 || eng_start) begin
          id = -1;
          for (int k = 0; k < N; k++)
            if (id < 0 && req_prev[(mptr + k) % N]) id = (mptr + k) % N;
          if (id < 0) begin
            check("spurious_gnt", {27'd0, eng_start, gnt}, 32'd0);
          end else begin
            w = data_prev[id*DW +: DW];
            check("gnt", {28'd0, gnt}, 32'(1 << id));
            check("eng_start", {31'd0, eng_start}, 32'd1);
            check("eng_data", {16'd0, eng_data}, {16'd0, w});
            mx = 0;
            for (int j = 0; j < N; j++) begin
              if (j == id) wc[j] = 0;
              else if (req_prev[j]) wc[j]++;
              else wc[j] = 0;
              if (wc[j] > mx) mx = wc[j];
            end
            check("fairness_wait", 32'(mx > N - 1), 32'd0);
            e.id = id;
            if (eng_delay >= 0 && eng_delay <= TO) begin
              e.gap = bgap(w);
              e.to  = 0;
              e.lat = eng_delay + 2;
            end else begin
              e.gap = 0;
              e.to  = 1;
              e.lat = TO + 2;
            end
            e.gcyc = cyc;
            sb_q.push_back(e);
            mptr = (id + 1) % N;
          end
        end
        if (resp_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("resp_id", {30'd0, resp_id}, 32'(e.id));
            check("resp_gap", {28'd0, resp_gap}, 32'(e.gap));
            check("resp_timeout", {31'd0, resp_timeout}, 32'(e.to));
            check("resp_latency", 32'(cyc - e.gcyc), 32'(e.lat));
            if (rand_delay) begin
              r = int'($urandom_range(0, 9));
              if (r == 0) eng_delay = -1;
              else if (r == 1) eng_delay = -2;
              else if (r == 2) eng_delay = 32;
              else if (r == 3) eng_delay = 31;
              else eng_delay = int'($urandom_range(0, 30));
            end
          end
        end
      end
      req_prev  = req;
      data_prev = req_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk_zero(input string tag);
    check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    check({tag, "_eng_start"}, {31'd0, eng_start}, 32'd0);
    check({tag, "_eng_data"}, {16'd0, eng_data}, 32'd0);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_id"}, {30'd0, resp_id}, 32'd0);
    check({tag, "_resp_gap"}, {28'd0, resp_gap}, 32'd0);
    check({tag, "_resp_timeout"}, {31'd0, resp_timeout}, 32'd0);
  endtask

  task automatic req_job(input int i, input logic [DW-1:0] w);
    bit seen;
    seen = 1'b0;
    req_data[i*DW +: DW] = w;
    req[i] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (gnt[i]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("gnt_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic requester(input int i, input int n, input int maxidle);
    logic [DW-1:0] w;
    int            s;
    for (int j = 0; j < n; j++) begin
      w = DW'($urandom);
      s = int'($urandom_range(0, 7));
      if (s == 0) w = 16'hffff;
      else if (s == 1) w = 16'h0000;
      else if (s == 2) w = 16'h8001;
      req_job(i, w);
      repeat ($urandom_range(1, maxidle)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int j = 0; j < N; j++) wc[j] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    eng_delay = 20;
    req_job(2, 16'h8001);
    wait_idle();

    eng_delay = -1;
    req_job(0, 16'hf00f);
    wait_idle();
    eng_delay = 4;
    req_job(0, 16'hf00f);
    wait_idle();

    eng_delay = 31;
    req_job(1, 16'h8001);
    wait_idle();
    eng_delay = -2;
    req_job(3, 16'h8001);
    wait_idle();

    eng_delay = 3;
    req_job(3, 16'hffff);
    wait_idle();
    req_job(0, 16'h0000);
    wait_idle();
    req_job(1, 16'h5555);
    wait_idle();
    req_job(2, 16'b1010_0100_0100_0010);
    wait_idle();

    eng_delay = 0;
    fork
      requester(0, 3, 1);
      requester(1, 3, 1);
      requester(2, 3, 1);
      requester(3, 3, 1);
    join
    wait_idle();

    rand_delay = 1'b1;
    eng_delay  = 5;
    fork
      requester(0, 6, 4);
      requester(1, 6, 4);
      requester(2, 6, 4);
      requester(3, 6, 4);
    join
    wait_idle();
    rand_delay = 1'b0;

    eng_delay = -1;
    req_job(1, 16'h1234);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    mptr = 0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midwait_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    eng_delay = 2;
    fork
      req_job(1, 16'h0101);
      req_job(3, 16'h4001);
    join
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
